iir_deemph: RTL and testbench
=============================

// Module: iir_deemph
// PURPOSE
// - FM de-emphasis stage: 1st-order fixed-point IIR, y[n] = Σ DQ(x[n-k]*b[k]) + DQ(y[n-1]*a1), k=0..1.
// - Sits directly downstream of the audio fir_top decimator: input FIFO -> iir_deemph -> output FIFO -> gain.
// - Uses the same FIFO read/write handshake as fir.
// - Bit-exact with the team software model; one output per input, no decimation.
// PARAMETERS
// - DATA_SIZE  32  sample width, signed two's complement.
// - BITS       10  fixed-point fraction bits (quantization scale 2^BITS).
// PORTS
// - clock       in   1          single clock; all state on rising edge.
// - reset       in   1          synchronous, active-high.
// - x_in        in   DATA_SIZE  input FIFO dout (FIFO shows head word when !x_empty).
// - x_rd_en     out  1          pop input FIFO; combinational.
// - x_empty     in   1          input FIFO empty.
// - y_out       out  DATA_SIZE  output FIFO din; registered.
// - y_out_full  in   1          output FIFO full.
// - y_wr_en     out  1          push output FIFO; combinational.
// BEHAVIOUR
// - Reset: state=S_IDLE; x_hist0, x_hist1, y_hist, products and y_out = 0.
//   - Combinational outputs x_rd_en and y_wr_en are 0 during reset.
// - Reset mid-operation: any in-flight sample is discarded; history is cleared.
// - FSM:
//   - S_IDLE:
//     - x_rd_en = !x_empty.
//     - On a pop: x_hist1 <= x_hist0, x_hist0 <= x_in, -> S_MULT.
//     - Otherwise stay.
//   - S_MULT:
//     - Register p0 = x_hist0*B0, p1 = x_hist1*B1, p2 = y_hist*A1.
//     - Full 2*DATA_SIZE signed products. -> S_SUM.
//   - S_SUM:
//     - y_out <= DQ(p0) + DQ(p1) + DQ(p2), each DQ truncated to DATA_SIZE.
//     - Sum wraps mod 2^DATA_SIZE; no saturation. -> S_WRITE.
//   - S_WRITE:
//     - y_wr_en = !y_out_full.
//     - On a push: y_hist <= y_out, -> S_IDLE.
//     - Otherwise hold y_out and stay.
// - DQ(v) = signed division by 2^BITS, rounding toward zero (C semantics).
//   - Implemented as (v + (v<0 ? 2^BITS-1 : 0)) >>> BITS. A plain >>> is non-compliant.
// - Latency: pop at cycle 0 -> y_wr_en earliest at cycle 3. Peak throughput 1 sample / 4 cycles.
// - Back-pressure: while y_out_full=1 in S_WRITE, nothing is popped.
//   - The input FIFO fills and upstream fir stalls naturally.
// - Reads and writes never occur in the same cycle: x_rd_en and y_wr_en are mutually exclusive by state.
// - Empty input: block idles indefinitely; history is preserved.
// - Never pops when x_empty=1; never pushes when y_out_full=1.
// STRUCTURE
// - iir_pkg:
//   - BITS, DATA_SIZE, coefficients IIR_B0 = 178, IIR_B1 = 178, IIR_A1 = -666
//     (QUANTIZE_F of W_PP/(1+W_PP) and (W_PP-1)/(W_PP+1), W_PP = 0.21140067).
//   - state_t enum {S_IDLE, S_MULT, S_SUM, S_WRITE}.
//   - Function dequantize().
// - Core has no sub-modules.
// - Companion wrapper iir_top instantiates fifo(16) -> iir_deemph -> fifo(16), mirroring fir_top.
// TESTING
// - Impulse: x = 1024, 0, 0 -> y = 178, 63, -40.
// - Rounding: from reset, x = -1 -> y = 0 (DQ(-178) = 0, not -1).
// - Back-pressure:
//   - Stimulus: hold y_out_full=1 for 10 cycles with 3 samples queued.
//   - Required: y_wr_en stays 0, exactly 1 pop occurs, y_out is stable.
//   - On release: 3 outputs emitted in order, values identical to the no-stall run.
// - Mid-op reset: pulse reset during S_SUM after impulse -> next x = 1024 yields 178 (history cleared).
// - Streaming vs. software model:
//   - Stimulus: 1000 random signed samples, random x_empty / y_out_full toggling.
//   - Required: bit-exact vs C model; no pop on empty, no push on full.
// - Wrap: x = 0x7FFFFFFF repeated -> outputs match model mod 2^32; no X, FSM never stalls.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the FM de-emphasis IIR.
package iir_pkg;

  localparam int DATA_SIZE = 32;
  localparam int BITS      = 10;
  localparam int PROD_SIZE = 2 * DATA_SIZE;

  // Quantised coefficients for W_PP = 0.21140067 at 2^BITS scale
  localparam logic signed [DATA_SIZE-1:0] IIR_B0 = 32'sd178;
  localparam logic signed [DATA_SIZE-1:0] IIR_B1 = 32'sd178;
  localparam logic signed [DATA_SIZE-1:0] IIR_A1 = -32'sd666;

  localparam logic signed [PROD_SIZE-1:0] DQ_BIAS = (64'sd1 <<< BITS) - 64'sd1;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_MULT  = 2'd1;
  localparam state_t S_SUM   = 2'd2;
  localparam state_t S_WRITE = 2'd3;

  function automatic logic signed [PROD_SIZE-1:0] sext(input logic signed [DATA_SIZE-1:0] v);
    return {{DATA_SIZE{v[DATA_SIZE-1]}}, v};
  endfunction

  // Divide by 2^BITS rounding toward zero: negative values are biased up before the shift
  function automatic logic signed [DATA_SIZE-1:0] dequantize(input logic signed [PROD_SIZE-1:0] v);
    logic signed [PROD_SIZE-1:0] biased;
    if (v[PROD_SIZE-1]) begin
      biased = v + DQ_BIAS;
    end else begin
      biased = v;
    end
    biased = biased >>> BITS;
    return biased[DATA_SIZE-1:0];
  endfunction

endpackage

// File: rtl/iir_deemph_if.sv
// FIFO-side handshake bundle for iir_deemph: input FIFO read port and output FIFO write port.
interface iir_deemph_if;
  import iir_pkg::*;

  logic signed [DATA_SIZE-1:0] x_in;
  logic                        x_rd_en;
  logic                        x_empty;
  logic signed [DATA_SIZE-1:0] y_out;
  logic                        y_out_full;
  logic                        y_wr_en;

  modport master (
    input  x_in, x_empty, y_out_full,
    output x_rd_en, y_out, y_wr_en
  );

  modport slave (
    output x_in, x_empty, y_out_full,
    input  x_rd_en, y_out, y_wr_en
  );

endinterface

// File: rtl/iir_deemph.sv
// First-order fixed-point de-emphasis IIR between two FIFOs; one output per input,
// y[n] = DQ(x[n]*B0) + DQ(x[n-1]*B1) + DQ(y[n-1]*A1).
module iir_deemph
  import iir_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  iir_deemph_if.master bus
);

  state_t                      state_q,   state_d;
  logic signed [DATA_SIZE-1:0] x_hist0_q, x_hist0_d;
  logic signed [DATA_SIZE-1:0] x_hist1_q, x_hist1_d;
  logic signed [DATA_SIZE-1:0] y_hist_q,  y_hist_d;
  logic signed [DATA_SIZE-1:0] y_out_q,   y_out_d;
  logic signed [PROD_SIZE-1:0] p0_q,      p0_d;
  logic signed [PROD_SIZE-1:0] p1_q,      p1_d;
  logic signed [PROD_SIZE-1:0] p2_q,      p2_d;
  logic                        rd_en;
  logic                        wr_en;

  // Next-state, datapath and FIFO strobes; strobes are forced low while reset is held
  always_comb begin
    state_d   = state_q;
    x_hist0_d = x_hist0_q;
    x_hist1_d = x_hist1_q;
    y_hist_d  = y_hist_q;
    y_out_d   = y_out_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    if (reset) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rd_en = !bus.x_empty;
          if (rd_en) begin
            x_hist1_d = x_hist0_q;
            x_hist0_d = bus.x_in;
            state_d   = S_MULT;
          end else begin
            state_d   = S_IDLE;
          end
        end
        S_MULT: begin
          p0_d    = sext(x_hist0_q) * sext(IIR_B0);
          p1_d    = sext(x_hist1_q) * sext(IIR_B1);
          p2_d    = sext(y_hist_q)  * sext(IIR_A1);
          state_d = S_SUM;
        end
        S_SUM: begin
          // Wraps modulo 2^DATA_SIZE by design; no saturation
          y_out_d = dequantize(p0_q) + dequantize(p1_q) + dequantize(p2_q);
          state_d = S_WRITE;
        end
        S_WRITE: begin
          wr_en = !bus.y_out_full;
          if (wr_en) begin
            y_hist_d = y_out_q;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_WRITE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers; reset discards any in-flight sample and clears history
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x_hist0_q <= 32'sd0;
      x_hist1_q <= 32'sd0;
      y_hist_q  <= 32'sd0;
      y_out_q   <= 32'sd0;
      p0_q      <= 64'sd0;
      p1_q      <= 64'sd0;
      p2_q      <= 64'sd0;
    end else begin
      state_q   <= state_d;
      x_hist0_q <= x_hist0_d;
      x_hist1_q <= x_hist1_d;
      y_hist_q  <= y_hist_d;
      y_out_q   <= y_out_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
    end
  end

  assign bus.x_rd_en = rd_en;
  assign bus.y_wr_en = wr_en;
  assign bus.y_out   = y_out_q;

endmodule

// File: tb/tb_iir_deemph.sv
// Bench for iir_deemph: emulated FIFOs, a C-style reference model and directed scenarios.
module tb_iir_deemph;
  import iir_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iir_deemph_if bus();

  iir_deemph dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int in_q[$];
  int got_q[$];
  int exp_q[$];
  bit hide_in    = 1'b0;
  bit full_force = 1'b0;
  bit pop;
  int pop_cnt = 0;
  int m_x0 = 0;
  int m_yh = 0;
  int ref_y[3];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // C semantics: integer division truncates toward zero
  function automatic int dq(input longint v);
    return int'(v / 64'sd1024);
  endfunction

  task automatic chk_got(input string name, input int idx, input longint exp);
    longint act;
    if (idx < got_q.size()) act = got_q[idx];
    else act = 64'sh7fff_ffff_ffff;
    chk(name, act, exp);
  endtask

  // Emulated input FIFO and output-full source, updated just after each rising edge
  initial begin
    bus.x_in       = 32'sd0;
    bus.x_empty    = 1'b1;
    bus.y_out_full = 1'b0;
    forever begin
      @(negedge clk);
      pop = bus.x_rd_en && !reset;
      @(posedge clk);
      #1;
      if (pop && in_q.size() > 0) void'(in_q.pop_front());
      bus.x_empty = hide_in || (in_q.size() == 0);
      if (in_q.size() > 0) bus.x_in = in_q[0];
      else bus.x_in = 32'sd0;
      bus.y_out_full = full_force;
    end
  end

  // Reference model and protocol checks, sampled on the falling edge
  always @(negedge clk) begin
    int y;
    if (reset) begin
      chk("rst_rd_en", bus.x_rd_en, 0);
      chk("rst_wr_en", bus.y_wr_en, 0);
      exp_q.delete();
      m_x0 = 0;
      m_yh = 0;
    end else begin
      if (bus.x_rd_en || bus.y_wr_en) chk("rd_wr_exclusive", bus.x_rd_en & bus.y_wr_en, 0);
      if (bus.x_rd_en) begin
        chk("pop_on_empty", bus.x_empty, 0);
        y = int'(longint'(dq(longint'(bus.x_in) * 178)) + dq(longint'(m_x0) * 178)
                 + dq(longint'(m_yh) * (-666)));
        exp_q.push_back(y);
        m_x0 = bus.x_in;
        m_yh = y;
        pop_cnt++;
      end
      if (bus.y_wr_en) begin
        chk("push_on_full", bus.y_out_full, 0);
        chk("y_out_known", $isunknown(bus.y_out), 0);
        if (exp_q.size() == 0) chk("unexpected_push", 1, 0);
        else chk("y_out_vs_model", bus.y_out, exp_q.pop_front());
        got_q.push_back(bus.y_out);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_q.delete();
    hide_in    = 1'b0;
    full_force = 1'b0;
    tick(3);
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    chk({name, "_out_count"}, got_q.size() >= n, 1);
  endtask

  initial begin
    int found;
    int y_a;
    int p0;
    int c;

    // Reset state
    do_reset();
    tick(1);
    chk("reset_y_out", bus.y_out, 0);
    chk("reset_rd_en_empty", bus.x_rd_en, 0);

    // Impulse response
    in_q.push_back(1024); in_q.push_back(0); in_q.push_back(0);
    wait_out(3, 60, "impulse");
    chk_got("impulse_y0", 0, 178);
    chk_got("impulse_y1", 1, 63);
    chk_got("impulse_y2", 2, -40);

    // Reset pulse while the next sample sits in S_SUM
    in_q.push_back(1024);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.x_rd_en) found = 1;
    end
    chk("midreset_pop_seen", found, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    got_q.delete();
    in_q.push_back(1024);
    wait_out(1, 40, "midreset");
    chk_got("midreset_y0", 0, 178);

    // Truncation toward zero on a negative product
    do_reset();
    in_q.push_back(-1);
    wait_out(1, 40, "round");
    chk_got("round_neg1", 0, 0);

    // Reference run without back-pressure
    do_reset();
    in_q.push_back(5000); in_q.push_back(-7000); in_q.push_back(123456);
    wait_out(3, 60, "nostall");
    for (int i = 0; i < 3; i++) ref_y[i] = (i < got_q.size()) ? got_q[i] : 0;

    // Same samples with the output FIFO held full
    do_reset();
    full_force = 1'b1;
    p0 = pop_cnt;
    in_q.push_back(5000); in_q.push_back(-7000); in_q.push_back(123456);
    tick(7);
    y_a = bus.y_out;
    chk("stall_y_out_value", y_a, ref_y[0]);
    tick(10);
    chk("stall_pop_count", pop_cnt - p0, 1);
    chk("stall_y_out_stable", bus.y_out, y_a);
    chk("stall_no_push", got_q.size(), 0);
    chk("stall_wr_en_low", bus.y_wr_en, 0);
    full_force = 1'b0;
    wait_out(3, 60, "release");
    for (int i = 0; i < 3; i++) chk_got("release_vs_nostall", i, ref_y[i]);

    // Wrap with full-scale positive input
    do_reset();
    for (int i = 0; i < 6; i++) in_q.push_back(32'h7FFF_FFFF);
    wait_out(6, 120, "wrap");
    chk_got("wrap_y0", 0, 373293055);

    // Random streaming with random empty/full toggling
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      if (i % 3 == 0) in_q.push_back(int'($urandom_range(0, 4000)) - 2000);
      else in_q.push_back(int'($urandom));
    end
    c = 0;
    while (got_q.size() < 1000 && c < 30000) begin
      hide_in    = ($urandom_range(0, 3) == 0);
      full_force = ($urandom_range(0, 3) == 0);
      tick(1);
      c++;
    end
    hide_in    = 1'b0;
    full_force = 1'b0;
    chk("stream_out_count", got_q.size(), 1000);
    tick(2);
    chk("stream_model_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
